inst_fetch: RTL and testbench
=============================

// Module: inst_fetch
// PURPOSE
//  Instruction fetch unit; producer side of the 32-bit instruction word consumed by InstDecoder.
//  Issues in-order word-aligned fetches to instruction memory, tags each returned word with its PC,
//  and buffers up to cFifoDepth words toward the decoder over a valid/ready handshake.
//  Handles redirects (branch/jump/trap) by flushing buffered and in-flight fetches.
// PARAMETERS
//  cResetPc    32'h0000_0000  PC fetched first after reset
//  cFifoDepth  2              output buffer entries, and max outstanding+buffered fetches (power of 2, >=2)
// PORTS
//  iClk         in   1   clock, all state on rising edge
//  iRst         in   1   asynchronous, active-high reset
//  iRedirect    in   1   pulse: restart fetch at iRedirectPc, discard everything older
//  iRedirectPc  in   32  new PC; bits [1:0] ignored (forced 0)
//  oMemReqValid out  1   fetch request valid
//  iMemReqReady in   1   memory accepts request this cycle
//  oMemReqAddr  out  32  fetch byte address, [1:0]=0
//  iMemRspValid in   1   response word valid; always accepted, strictly in request order
//  iMemRspData  in   32  instruction word
//  iMemRspErr   in   1   access fault for this response
//  oInstValid   out  1   oInst/oInstPc/oInstErr valid toward decoder
//  iInstReady   in   1   decoder consumes head entry
//  oInst        out  32  instruction word (32'h0000_0013 NOP when empty)
//  oInstPc      out  32  PC of oInst
//  oInstErr     out  1   oInst came from a faulted fetch
// BEHAVIOUR
//  Reset: oMemReqValid=0, oMemReqAddr=cResetPc, oInstValid=0, oInst=32'h0000_0013, oInstPc=0,
//   oInstErr=0; FIFO empty; outstanding=0; dropCnt=0; rspPc=cResetPc; state=RUN. Reset mid-operation
//   abandons all in-flight fetches; memory side is reset together with this block.
//  State machine: RUN -> HALT when a response with iMemRspErr=1 is pushed; HALT -> RUN on iRedirect.
//   No new requests in HALT.
//  Credit: request may be valid only if state=RUN and outstanding + fifoCount < cFifoDepth, so a
//   response always finds a free FIFO slot. Never overflows; no back-pressure on responses.
//  Request: oMemReqValid/oMemReqAddr registered; addr held stable while valid && !ready.
//   Accept (valid&&ready): outstanding+1, oMemReqAddr+=4 (wraps 32'hFFFF_FFFC -> 0).
//   First request: oMemReqValid=1 in first clock after iRst deasserts.
//  Response: outstanding-1. If dropCnt>0: discard, dropCnt-1. Else if state=HALT: discard.
//   Else push {iMemRspData, rspPc, iMemRspErr}, rspPc+=4. Push visible on oInstValid next cycle.
//  Output: oInst/oInstPc/oInstErr = FIFO head; pop on oInstValid&&iInstReady. Simultaneous push
//   and pop legal at any occupancy, including full.
//  Redirect (cycle N): FIFO flushed, oInstValid=0 at N+1; dropCnt <= outstanding + reqAccepted(N)
//   - rspConsumed(N) (response arriving in cycle N is discarded, not pushed, and does not count);
//   oMemReqAddr=rspPc=iRedirectPc&~3 at N+1; oMemReqValid may be withdrawn/retargeted at N+1
//   (memory tolerates a withdrawn, unaccepted request). A pop in cycle N is honoured.
//  Redirect with dropCnt>0 from an earlier redirect: new dropCnt per formula above (replaces).
//  Counter widths: outstanding, fifoCount, dropCnt are $clog2(cFifoDepth)+1 bits; no overflow.
// TESTING
//  1 Reset release, iMemReqReady=1, 1-cycle memory -> addrs 0,4,8.. ; oInstPc 0,4,8 with matching
//    data; no gaps once pipeline fills; never >2 outstanding+buffered.
//  2 iInstReady=0 for 10 cycles -> exactly 2 words buffered, oMemReqValid=0; release -> stream
//    resumes in order, no word lost or duplicated.
//  3 iRedirect to 32'h0000_1003 with 2 fetches in flight -> both responses dropped; next oInstPc
//    32'h0000_1000; oMemReqAddr=32'h0000_1000 the cycle after redirect.
//  4 Response with iMemRspErr=1 at PC 8 -> oInstErr=1 with oInstPc=8, later responses dropped,
//    no requests until iRedirect to 32'h40 -> fetch resumes at 32'h40, oInstErr=0.
//  5 Redirect same cycle as response and request accept -> that response not pushed, accepted
//    request's response dropped; oInst after redirect is from new PC only.
//  6 iRst asserted mid-stream (async, between edges) -> outputs to reset values immediately;
//    after release fetch restarts at cResetPc; random ready/latency soak vs. reference PC model.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch unit: credit-limited in-order fetch toward memory, PC-tagged output FIFO to the decoder.
// Redirects flush buffered words and drop responses still owed by memory for the old stream.
module inst_fetch #(
  parameter logic [31:0] cResetPc   = 32'h0000_0000,
  parameter int          cFifoDepth = 2
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iRedirect,
  input  logic [31:0] iRedirectPc,
  output logic        oMemReqValid,
  input  logic        iMemReqReady,
  output logic [31:0] oMemReqAddr,
  input  logic        iMemRspValid,
  input  logic [31:0] iMemRspData,
  input  logic        iMemRspErr,
  output logic        oInstValid,
  input  logic        iInstReady,
  output logic [31:0] oInst,
  output logic [31:0] oInstPc,
  output logic        oInstErr
);

  localparam int cCntW = $clog2(cFifoDepth) + 1;
  localparam int cPtrW = $clog2(cFifoDepth);
  localparam logic [cCntW:0] cDepthW = (cCntW + 1)'(cFifoDepth);
  localparam logic [31:0] cNop = 32'h0000_0013;

  typedef enum logic {RUN, HALT} tState;

  tState            r_state;
  logic [cCntW-1:0] r_outstanding;
  logic [cCntW-1:0] r_fifoCount;
  logic [cCntW-1:0] r_dropCnt;
  logic [cPtrW-1:0] r_rdPtr;
  logic [cPtrW-1:0] r_wrPtr;
  logic [31:0]      r_rspPc;
  logic             r_reqValid;
  logic [31:0]      r_reqAddr;
  logic [31:0]      r_fifoData [cFifoDepth];
  logic [31:0]      r_fifoPc   [cFifoDepth];
  logic             r_fifoErr  [cFifoDepth];

  tState            w_nextState;
  logic             w_reqAccept;
  logic             w_push;
  logic             w_pop;
  logic [cCntW-1:0] w_nextOutstanding;
  logic [cCntW-1:0] w_nextCount;
  logic [cCntW-1:0] w_nextDrop;
  logic [cCntW:0]   w_creditSum;
  logic             w_nextReqValid;
  logic [31:0]      w_redirectPc;

  assign w_redirectPc = iRedirectPc & 32'hFFFF_FFFC;
  assign w_reqAccept  = r_reqValid && iMemReqReady;
  assign w_pop        = oInstValid && iInstReady;
  // A response arriving in the redirect cycle belongs to the old stream, so it is never pushed.
  assign w_push       = iMemRspValid && !iRedirect && (r_dropCnt == '0) && (r_state == RUN);

  assign w_nextOutstanding = r_outstanding + cCntW'(w_reqAccept) - cCntW'(iMemRspValid);
  assign w_nextCount = iRedirect ? '0 : (r_fifoCount + cCntW'(w_push) - cCntW'(w_pop));
  assign w_nextDrop = iRedirect ? w_nextOutstanding :
                      ((iMemRspValid && (r_dropCnt != '0)) ? (r_dropCnt - cCntW'(1)) : r_dropCnt);
  assign w_creditSum = {1'b0, w_nextOutstanding} + {1'b0, w_nextCount};
  assign w_nextReqValid = (w_nextState == RUN) && (w_creditSum < cDepthW);

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    if (iRedirect) begin
      w_nextState = RUN;
    end else if (w_push && iMemRspErr) begin
      w_nextState = HALT;
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_outstanding <= '0;
      r_fifoCount   <= '0;
      r_dropCnt     <= '0;
      r_rdPtr       <= '0;
      r_wrPtr       <= '0;
      r_rspPc       <= cResetPc;
      r_reqValid    <= 1'b0;
      r_reqAddr     <= cResetPc;
    end else begin
      r_outstanding <= w_nextOutstanding;
      r_fifoCount   <= w_nextCount;
      r_dropCnt     <= w_nextDrop;
      r_reqValid    <= w_nextReqValid;
      if (iRedirect) begin
        r_rdPtr   <= '0;
        r_wrPtr   <= '0;
        r_rspPc   <= w_redirectPc;
        r_reqAddr <= w_redirectPc;
      end else begin
        if (w_pop) begin
          r_rdPtr <= r_rdPtr + cPtrW'(1);
        end
        if (w_push) begin
          r_wrPtr <= r_wrPtr + cPtrW'(1);
          r_rspPc <= r_rspPc + 32'd4;
        end
        if (w_reqAccept) begin
          r_reqAddr <= r_reqAddr + 32'd4;
        end
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (w_push) begin
      r_fifoData[r_wrPtr] <= iMemRspData;
      r_fifoPc[r_wrPtr]   <= r_rspPc;
      r_fifoErr[r_wrPtr]  <= iMemRspErr;
    end
  end

  assign oMemReqValid = r_reqValid;
  assign oMemReqAddr  = r_reqAddr;
  assign oInstValid   = (r_fifoCount != '0);
  assign oInst        = oInstValid ? r_fifoData[r_rdPtr] : cNop;
  assign oInstPc      = oInstValid ? r_fifoPc[r_rdPtr] : 32'h0000_0000;
  assign oInstErr     = oInstValid ? r_fifoErr[r_rdPtr] : 1'b0;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: behavioural memory with configurable latency/ready and a
// reference PC model that checks every word the decoder side consumes.
module tb_inst_fetch;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iRedirect;
  logic [31:0] iRedirectPc;
  logic        oMemReqValid;
  logic        iMemReqReady = 1'b1;
  logic [31:0] oMemReqAddr;
  logic        iMemRspValid = 1'b0;
  logic [31:0] iMemRspData = 32'h0;
  logic        iMemRspErr = 1'b0;
  logic        oInstValid;
  logic        iInstReady;
  logic [31:0] oInst;
  logic [31:0] oInstPc;
  logic        oInstErr;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } tMemEnt;

  tMemEnt      memQ[$];
  int          memCyc = 0;
  logic        randomMode = 1'b0;
  logic        randInst = 1'b0;
  int          fixedLat = 1;
  logic [31:0] errAddr = 32'hFFFF_FFFF;
  logic        streamOn = 1'b0;
  logic [31:0] expPc = 32'h0;
  logic [31:0] lastPc = 32'hFFFF_FFFF;
  logic        lastErr = 1'b0;
  int          consumed = 0;
  int          checks = 0;
  int          errors = 0;

  inst_fetch #(.cResetPc(32'h0000_0000), .cFifoDepth(2)) dut (
    .iClk(iClk), .iRst(iRst), .iRedirect(iRedirect), .iRedirectPc(iRedirectPc),
    .oMemReqValid(oMemReqValid), .iMemReqReady(iMemReqReady), .oMemReqAddr(oMemReqAddr),
    .iMemRspValid(iMemRspValid), .iMemRspData(iMemRspData), .iMemRspErr(iMemRspErr),
    .oInstValid(oInstValid), .iInstReady(iInstReady), .oInst(oInst), .oInstPc(oInstPc),
    .oInstErr(oInstErr)
  );

  always #5 iClk = ~iClk;

  function automatic logic [31:0] memData(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Memory decides acceptance for the coming edge and returns responses strictly in order.
  always begin
    tMemEnt ent;
    int     lat;
    @(posedge iClk);
    #1;
    if (iRst) begin
      memQ.delete();
      iMemRspValid = 1'b0;
      iMemRspData  = 32'h0;
      iMemRspErr   = 1'b0;
      iMemReqReady = 1'b1;
      memCyc       = 0;
    end else begin
      if (memQ.size() > 0 && memQ[0].due <= memCyc) begin
        ent = memQ.pop_front();
        iMemRspValid = 1'b1;
        iMemRspData  = memData(ent.addr);
        iMemRspErr   = (ent.addr == errAddr);
      end else begin
        iMemRspValid = 1'b0;
        iMemRspData  = 32'h0;
        iMemRspErr   = 1'b0;
      end
      iMemReqReady = randomMode ? 1'($urandom_range(0, 1)) : 1'b1;
      if (oMemReqValid && iMemReqReady) begin
        lat = randomMode ? int'($urandom_range(1, 3)) : fixedLat;
        memQ.push_back('{addr: oMemReqAddr, due: memCyc + lat});
      end
      memCyc++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkTrue(input string tag, input logic cond);
    checkOutput(tag, {31'b0, cond}, 32'd1);
  endtask

  // Words popped at the coming edge are compared against the reference PC stream.
  task automatic applyStimulus();
    if (streamOn && oInstValid && iInstReady) begin
      checkOutput("instPc", oInstPc, expPc);
      checkOutput("inst", oInst, memData(expPc));
      checkOutput("instErr", {31'b0, oInstErr}, {31'b0, (expPc == errAddr)});
      lastPc  = expPc;
      lastErr = oInstErr;
      consumed++;
      expPc = expPc + 32'd4;
    end
    @(posedge iClk);
    #2;
    if (randInst) iInstReady = 1'($urandom_range(0, 1));
  endtask

  task automatic waitConsumed(input logic [31:0] pc, input string tag);
    for (int i = 0; i < 200 && lastPc != pc; i++) applyStimulus();
    checkOutput(tag, lastPc, pc);
  endtask

  task automatic redirectTo(input logic [31:0] pc);
    iRedirect   = 1'b1;
    iRedirectPc = pc;
    applyStimulus();
    iRedirect = 1'b0;
    expPc     = pc & 32'hFFFF_FFFC;
    lastPc    = 32'hFFFF_FFFF;
  endtask

  initial begin
    int   startCnt;
    logic found;
    iRst = 1'b1;
    iRedirect = 1'b0;
    iRedirectPc = 32'h0;
    iInstReady = 1'b1;
    applyStimulus();
    applyStimulus();
    checkOutput("rstReqValid", {31'b0, oMemReqValid}, 32'd0);
    checkOutput("rstReqAddr", oMemReqAddr, 32'h0);
    checkOutput("rstInstValid", {31'b0, oInstValid}, 32'd0);
    checkOutput("rstInst", oInst, 32'h0000_0013);
    checkOutput("rstInstPc", oInstPc, 32'h0);
    checkOutput("rstInstErr", {31'b0, oInstErr}, 32'd0);

    // Stream from reset PC with a one-cycle memory
    iRst = 1'b0;
    streamOn = 1'b1;
    applyStimulus();
    checkOutput("firstReqValid", {31'b0, oMemReqValid}, 32'd1);
    checkOutput("firstReqAddr", oMemReqAddr, 32'h0);
    applyStimulus();
    checkOutput("secondReqAddr", oMemReqAddr, 32'h4);
    repeat (20) applyStimulus();
    checkTrue("t1Progress", consumed >= 6);

    // Decoder stall: two words buffered, requests stop
    iInstReady = 1'b0;
    repeat (10) applyStimulus();
    checkOutput("stallInstValid", {31'b0, oInstValid}, 32'd1);
    checkOutput("stallReqValid", {31'b0, oMemReqValid}, 32'd0);
    checkOutput("stallHeadPc", oInstPc, expPc);
    checkOutput("stallInFlight", memQ.size(), 32'd0);
    iInstReady = 1'b1;
    applyStimulus();
    checkOutput("stallSecondValid", {31'b0, oInstValid}, 32'd1);
    checkOutput("stallSecondPc", oInstPc, expPc);
    applyStimulus();
    checkOutput("stallDrained", {31'b0, oInstValid}, 32'd0);
    repeat (6) applyStimulus();

    // Redirect with two fetches in flight
    fixedLat = 3;
    for (int i = 0; i < 30 && memQ.size() != 2; i++) applyStimulus();
    checkOutput("t3InFlight", memQ.size(), 32'd2);
    redirectTo(32'h0000_1003);
    checkOutput("t3ReqAddr", oMemReqAddr, 32'h0000_1000);
    checkOutput("t3Flushed", {31'b0, oInstValid}, 32'd0);
    waitConsumed(32'h0000_1000, "t3NewPc");
    fixedLat = 1;
    repeat (6) applyStimulus();

    // Access fault halts fetch until redirected
    errAddr = 32'h8;
    redirectTo(32'h0);
    waitConsumed(32'h8, "t4ErrPc");
    checkOutput("t4ErrFlag", {31'b0, lastErr}, 32'd1);
    repeat (8) applyStimulus();
    checkOutput("t4HaltInst", {31'b0, oInstValid}, 32'd0);
    checkOutput("t4HaltReq", {31'b0, oMemReqValid}, 32'd0);
    errAddr = 32'hFFFF_FFFF;
    redirectTo(32'h40);
    checkOutput("t4ReqAddr", oMemReqAddr, 32'h40);
    waitConsumed(32'h40, "t4ResumePc");
    checkOutput("t4ResumeErr", {31'b0, lastErr}, 32'd0);
    repeat (6) applyStimulus();

    // Redirect coinciding with a response and a request accept
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (iMemRspValid && oMemReqValid && iMemReqReady) found = 1'b1;
      else applyStimulus();
    end
    checkTrue("t5Coincide", found);
    redirectTo(32'h200);
    checkOutput("t5ReqAddr", oMemReqAddr, 32'h200);
    waitConsumed(32'h200, "t5NewPc");
    repeat (5) applyStimulus();

    // Asynchronous reset between edges
    #4;
    iRst = 1'b1;
    #1;
    checkOutput("t6ReqValid", {31'b0, oMemReqValid}, 32'd0);
    checkOutput("t6ReqAddr", oMemReqAddr, 32'h0);
    checkOutput("t6InstValid", {31'b0, oInstValid}, 32'd0);
    checkOutput("t6Inst", oInst, 32'h0000_0013);
    checkOutput("t6InstPc", oInstPc, 32'h0);
    streamOn = 1'b0;
    @(posedge iClk);
    #2;
    iRst = 1'b0;
    expPc = 32'h0;
    lastPc = 32'hFFFF_FFFF;
    streamOn = 1'b1;
    waitConsumed(32'h0, "t6RestartPc");

    // Random ready/latency soak with redirects, including address wrap
    randomMode = 1'b1;
    randInst = 1'b1;
    startCnt = consumed;
    repeat (60) applyStimulus();
    redirectTo(32'hFFFF_FFF5);
    waitConsumed(32'h0, "t6WrapPc");
    repeat (60) applyStimulus();
    redirectTo($urandom & 32'h000F_FFFF);
    repeat (80) applyStimulus();
    checkTrue("t6SoakProgress", (consumed - startCnt) >= 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
